// File: rtl/dmem_wait_responder_if.sv
// Load/store handshake bundle between the core (master) and dmem_wait_responder (slave).
interface dmem_wait_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output rdata, ready, err
    );
endinterface

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with req/ready handshake and WAIT programmable wait states.
// Define DMEM_BYTE_STROBE_EN to make stores honour wstrb; otherwise stores write all four bytes.
module dmem_wait_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_wait_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          fault_q, fault_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    lanes;
    logic          accept;
    logic          req_fault;
    logic          mem_wr;
    logic [31:0]   mem_q [DEPTH];

    assign accept    = (state_q == ST_IDLE) && bus.req;
    assign req_fault = (bus.addr[1:0] != 2'b00) || (bus.addr[31:AW+2] != '0);
    assign mem_wr    = (state_q == ST_RESP) && we_q && !fault_q;

`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0] wstrb_q, wstrb_d;

    always_comb begin
        wstrb_d = wstrb_q;
        if (accept) begin
            wstrb_d = bus.wstrb;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wstrb_q <= 4'h0;
        end else begin
            wstrb_q <= wstrb_d;
        end
    end

    assign lanes = wstrb_q;
`else
    assign lanes = 4'hF;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        fault_d = fault_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    fault_d = req_fault;
                    idx_d   = bus.addr[AW+1:2];
                    wdata_d = bus.wdata;
                    cnt_d   = 4'(WAIT);
                    state_d = (WAIT > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // ready/err/rdata are registered, so they appear in the cycle after RESP,
                // which is also the IDLE cycle where the next request can be sampled.
                ready_d = 1'b1;
                err_d   = fault_q;
                if (fault_q) begin
                    rdata_d = 32'h0;
                end else if (!we_q) begin
                    rdata_d = mem_q[idx_q];
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            fault_q <= fault_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory is intentionally not reset; a reset during a transaction leaves state_q in IDLE,
    // so a pending store never reaches this write.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench for dmem_wait_responder: a WAIT=2 instance under directed and random traffic,
// plus a WAIT=0 instance driven back-to-back with req held high.
module tb_dmem_wait_responder;
    localparam int DEPTH = 64;
    localparam int WAIT  = 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_wait_responder_if bus();
    dmem_wait_responder_if bus0();

    dmem_wait_responder #(.DEPTH(DEPTH), .WAIT(WAIT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dmem_wait_responder #(.DEPTH(DEPTH), .WAIT(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] mask;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem   [DEPTH];
    logic [3:0]  model_valid [DEPTH];
    logic [31:0] last_rdata;
    logic [31:0] last_mask;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected, input logic [31:0] mask);
        total++;
        if ((actual & mask) !== (expected & mask)) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h (mask %h)", name, actual, expected, mask);
        end
    endtask

    // Monitor: every ready pulse of the WAIT=2 instance must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.ready === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_ready", 32'(bus.ready), 32'h0, 32'h1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_err"}, 32'(bus.err), 32'(e.err), 32'h1);
                checkOutput({e.name, "_rdata"}, bus.rdata, e.rdata, e.mask);
                checkOutput({e.name, "_latency"}, 32'(cyc), 32'(e.due), 32'hFFFF_FFFF);
            end
        end
    end

    // Issues one request at a negedge and returns at the negedge where ready is seen.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input string name);
        exp_t       e;
        logic       fault;
        logic [3:0] wr_lanes;
        int         idx;
        int         n;
        fault  = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
        idx    = int'(addr / 4);
        e.name = name;
        e.due  = cyc + WAIT + 2;
        if (fault) begin
            e.err      = 1'b1;
            e.rdata    = 32'h0;
            e.mask     = 32'hFFFF_FFFF;
            last_rdata = 32'h0;
            last_mask  = 32'hFFFF_FFFF;
        end else if (we) begin
`ifdef DMEM_BYTE_STROBE_EN
            wr_lanes = wstrb;
`else
            wr_lanes = 4'hF;
`endif
            for (int b = 0; b < 4; b++) begin
                if (wr_lanes[b]) begin
                    model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                    model_valid[idx][b]      = 1'b1;
                end
            end
            e.err   = 1'b0;
            e.rdata = last_rdata;
            e.mask  = last_mask;
        end else begin
            e.err   = 1'b0;
            e.rdata = model_mem[idx];
            e.mask  = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (model_valid[idx][b]) e.mask[8*b +: 8] = 8'hFF;
            end
            last_rdata = e.rdata;
            last_mask  = e.mask;
        end
        sb.push_back(e);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.wstrb = wstrb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ready !== 1'b1 && n < 40);
        if (bus.ready !== 1'b1) begin
            checkOutput({name, "_timeout"}, 32'(bus.ready), 32'h1, 32'h1);
        end
        bus.req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] d0 [8];
        logic [31:0] addr;
        int          r;
        int          nrdy;
        int          last_t;

        reset      = 1'b0;
        bus.req    = 1'b0;  bus.we  = 1'b0;  bus.addr  = '0; bus.wdata  = '0; bus.wstrb  = '0;
        bus0.req   = 1'b0;  bus0.we = 1'b0;  bus0.addr = '0; bus0.wdata = '0; bus0.wstrb = '0;
        last_rdata = 32'h0;
        last_mask  = 32'hFFFF_FFFF;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = 32'h0;
            model_valid[i] = 4'h0;
        end

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", 32'(bus.ready), 32'h0, 32'h1);
        checkOutput("reset_err", 32'(bus.err), 32'h0, 32'h1);
        checkOutput("reset_rdata", bus.rdata, 32'h0, 32'hFFFF_FFFF);
        checkOutput("reset_ready0", 32'(bus0.ready), 32'h0, 32'h1);
        checkOutput("reset_rdata0", bus0.rdata, 32'h0, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        $display("[TB] reset checks done");

        applyStimulus(1'b1, 32'd100, 32'd25, 4'hF, "st100");
        applyStimulus(1'b0, 32'd100, 32'h0, 4'h0, "ld100");
        applyStimulus(1'b1, 32'd96, 32'hFFFF_FFFF, 4'hF, "st96_ones");
        applyStimulus(1'b1, 32'd96, 32'h0000_00AB, 4'b0001, "st96_lane0");
        applyStimulus(1'b0, 32'd96, 32'h0, 4'h0, "ld96");
        applyStimulus(1'b0, 32'd102, 32'h0, 4'h0, "ld_misaligned");
        applyStimulus(1'b1, 32'd256, 32'hDEAD_BEEF, 4'hF, "st_oob");
        applyStimulus(1'b0, 32'd96, 32'h0, 4'h0, "ld96_after_oob");
        applyStimulus(1'b0, 32'd100, 32'h0, 4'h0, "ld100_after_oob");
        applyStimulus(1'b1, 32'd100, 32'h1234_5678, 4'h0, "st100_nostrobe");
        applyStimulus(1'b0, 32'd100, 32'h0, 4'h0, "ld100_nostrobe");
        $display("[TB] directed transactions issued");

        // Reset in the middle of a store's wait window must drop it silently.
        applyStimulus(1'b1, 32'd100, 32'h11, 4'hF, "seed100");
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'd100;
        bus.wdata = 32'h55;
        bus.wstrb = 4'hF;
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 1'b0;
        @(negedge clk);
        checkOutput("midreset_ready", 32'(bus.ready), 32'h0, 32'h1);
        checkOutput("midreset_rdata", bus.rdata, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b1;
        last_rdata = 32'h0;
        last_mask  = 32'hFFFF_FFFF;
        repeat (WAIT + 4) @(negedge clk);
        applyStimulus(1'b0, 32'd100, 32'h0, 4'h0, "ld100_after_reset");

        for (int t = 0; t < 80; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
            end else if (r == 7) begin
                addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            end else begin
                addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 100000));
            end
            applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        $display("[TB] random transactions issued");

        // WAIT=0 instance: req held high for 8 stores then 8 loads, one completion every 2 cycles.
        for (int i = 0; i < 8; i++) d0[i] = $urandom;
        bus0.req   = 1'b1;
        bus0.we    = 1'b1;
        bus0.wstrb = 4'hF;
        bus0.addr  = 32'h0;
        bus0.wdata = d0[0];
        nrdy       = 0;
        last_t     = cyc;
        for (int c = 0; c < 60 && nrdy < 16; c++) begin
            @(negedge clk);
            if (bus0.ready === 1'b1) begin
                checkOutput("w0_spacing", 32'(cyc - last_t), 32'd2, 32'hFFFF_FFFF);
                checkOutput("w0_err", 32'(bus0.err), 32'h0, 32'h1);
                if (nrdy >= 8) checkOutput("w0_load", bus0.rdata, d0[nrdy-8], 32'hFFFF_FFFF);
                last_t = cyc;
                nrdy++;
                if (nrdy < 8) begin
                    bus0.addr  = 32'(nrdy * 4);
                    bus0.wdata = d0[nrdy];
                end else if (nrdy < 16) begin
                    bus0.we   = 1'b0;
                    bus0.addr = 32'((nrdy - 8) * 4);
                end else begin
                    bus0.req = 1'b0;
                end
            end
        end
        bus0.req = 1'b0;
        checkOutput("w0_count", 32'(nrdy), 32'd16, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        checkOutput("w0_quiet", 32'(bus0.ready), 32'h0, 32'h1);

        repeat (WAIT + 4) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'h0, 32'hFFFF_FFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
